spi_regfile_sync: RTL



---
 rtl/spi_regfile_pkg.sv | 32 +++
 rtl/spi_regfile_sync_pin.sv | 32 +++
 rtl/spi_regfile_sync.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared state encoding and address-map decode helpers for the SPI register file.
package spi_regfile_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    // True when addr falls in the writable window 1..n_wr.
    function automatic logic addr_is_wr(input logic [15:0] addr, input logic [15:0] n_wr);
        return (addr >= 16'd1) && (addr <= n_wr);
    endfunction

    // True when addr falls in the read-only window n_wr+1..n_wr+n_rd.
    function automatic logic addr_is_rd(input logic [15:0] addr, input logic [15:0] n_wr,
                                        input logic [15:0] n_rd);
        return (addr > n_wr) && (addr <= (n_wr + n_rd));
    endfunction

    // Slice index inside whichever window addr belongs to.
    function automatic logic [15:0] addr_index(input logic [15:0] addr, input logic [15:0] n_wr);
        logic [15:0] idx;
        if (addr <= n_wr) begin
            idx = addr - 16'd1;
        end else begin
            idx = addr - n_wr - 16'd1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_regfile_sync_pin.sv
// Pad conditioning: two-flop synchroniser plus a history flop for edge detection.
module spi_pin_sync (
    input  logic iclk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronise the asynchronous pin and keep one cycle of history.
    always_ff @(posedge iclk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= pin;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;
    assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/spi_regfile_sync.sv
// Oversampled SPI (mode 0) register file: address byte then auto-incrementing data words.
module spi_regfile_sync
    import spi_regfile_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int N_WR    = 3,
    parameter int N_RD    = 56,
    parameter int IDLE_TO = 64
) (
    input  logic                     iclk,
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     serial_in,
    input  logic [N_RD*DATA_W-1:0]   rd_regs,
    output logic                     serial_out,
    output logic [N_WR*DATA_W-1:0]   wr_regs,
    output logic [N_WR-1:0]          wr_strobe,
    output logic                     frame_active
);

    localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam int TO_W  = $clog2(IDLE_TO);

    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(IDLE_TO - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WR + N_RD);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] TOP_ADDR  = {ADDR_W{1'b1}};

    logic sclk_level_unused_s, sclk_rise_s, sclk_fall_s, sclk_edge_s;
    logic din_s, din_rise_unused_s, din_fall_unused_s;

    state_t                 state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic [TO_W-1:0]        hold_cnt_r;
    logic                   hold_r;
    logic [ADDR_W-1:0]      ptr_r;
    logic [SH_W-2:0]        in_shift_r;
    logic [DATA_W-1:0]      out_shift_r;
    logic                   serial_out_r;
    logic                   frame_active_r;
    logic [N_WR*DATA_W-1:0] wr_regs_r;
    logic [N_WR-1:0]        wr_strobe_r;

    logic [SH_W-1:0]        shift_next_s;
    logic [ADDR_W-1:0]      ptr_inc_s;
    logic [ADDR_W-1:0]      rd_addr_s;
    logic [DATA_W-1:0]      rd_word_s;
    logic [N_WR-1:0]        wr_hit_s;

    spi_pin_sync u_sclk_sync (
        .iclk  (iclk),
        .rst   (rst),
        .pin   (sclk),
        .level (sclk_level_unused_s),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    spi_pin_sync u_din_sync (
        .iclk  (iclk),
        .rst   (rst),
        .pin   (serial_in),
        .level (din_s),
        .rise  (din_rise_unused_s),
        .fall  (din_fall_unused_s)
    );

    assign sclk_edge_s  = sclk_rise_s | sclk_fall_s;
    assign shift_next_s = {in_shift_r, din_s};

    // Pointer advance: wraps to 1 past the last mapped register and past the top address.
    always_comb begin
        if ((ptr_r == LAST_ADDR) || (ptr_r == TOP_ADDR)) begin
            ptr_inc_s = ONE_ADDR;
        end else begin
            ptr_inc_s = ptr_r + ONE_ADDR;
        end
    end

    // Address to preload: freshly received address in ADDR, next pointer in DATA.
    always_comb begin
        if (state_r == ST_ADDR) begin
            rd_addr_s = shift_next_s[ADDR_W-1:0];
        end else begin
            rd_addr_s = ptr_inc_s;
        end
    end

    // Read map: writable slices, then read-only inputs, zero elsewhere.
    always_comb begin
        rd_word_s = {DATA_W{1'b0}};
        for (int k = 0; k < N_WR; k++) begin
            rd_word_s = rd_word_s |
                ((addr_is_wr(16'(rd_addr_s), 16'(N_WR)) &&
                  (addr_index(16'(rd_addr_s), 16'(N_WR)) == 16'(k))) ?
                 wr_regs_r[k*DATA_W +: DATA_W] : {DATA_W{1'b0}});
        end
        for (int k = 0; k < N_RD; k++) begin
            rd_word_s = rd_word_s |
                ((addr_is_rd(16'(rd_addr_s), 16'(N_WR), 16'(N_RD)) &&
                  (addr_index(16'(rd_addr_s), 16'(N_WR)) == 16'(k))) ?
                 rd_regs[k*DATA_W +: DATA_W] : {DATA_W{1'b0}});
        end
    end

    // One-hot select of the writable register addressed by the current pointer.
    always_comb begin
        wr_hit_s = {N_WR{1'b0}};
        for (int k = 0; k < N_WR; k++) begin
            wr_hit_s[k] = addr_is_wr(16'(ptr_r), 16'(N_WR)) &&
                          (addr_index(16'(ptr_r), 16'(N_WR)) == 16'(k));
        end
    end

    // Frame sequencer: post-reset hold, address/data parsing, commit, shift-out and timeout.
    always_ff @(posedge iclk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            bit_cnt_r      <= {CNT_W{1'b0}};
            to_cnt_r       <= {TO_W{1'b0}};
            hold_cnt_r     <= {TO_W{1'b0}};
            hold_r         <= 1'b1;
            ptr_r          <= {ADDR_W{1'b0}};
            in_shift_r     <= {(SH_W-1){1'b0}};
            out_shift_r    <= {DATA_W{1'b0}};
            serial_out_r   <= 1'b0;
            frame_active_r <= 1'b0;
            wr_regs_r      <= {(N_WR*DATA_W){1'b0}};
            wr_strobe_r    <= {N_WR{1'b0}};
        end else begin
            wr_strobe_r <= {N_WR{1'b0}};
            if (hold_r) begin
                // Swallow the tail of any frame cut short by reset until sclk goes quiet.
                if (sclk_edge_s) begin
                    hold_cnt_r <= {TO_W{1'b0}};
                end else if (hold_cnt_r == TO_LAST) begin
                    hold_r     <= 1'b0;
                    hold_cnt_r <= {TO_W{1'b0}};
                end else begin
                    hold_cnt_r <= hold_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        to_cnt_r <= {TO_W{1'b0}};
                        if (sclk_rise_s) begin
                            in_shift_r     <= shift_next_s[SH_W-2:0];
                            bit_cnt_r      <= {{(CNT_W-1){1'b0}}, 1'b1};
                            frame_active_r <= 1'b1;
                            state_r        <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise_s) begin
                            in_shift_r <= shift_next_s[SH_W-2:0];
                            if (bit_cnt_r == ADDR_LAST) begin
                                ptr_r       <= shift_next_s[ADDR_W-1:0];
                                out_shift_r <= rd_word_s;
                                bit_cnt_r   <= {CNT_W{1'b0}};
                                state_r     <= ST_DATA;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise_s) begin
                            in_shift_r <= shift_next_s[SH_W-2:0];
                            if (bit_cnt_r == DATA_LAST) begin
                                for (int k = 0; k < N_WR; k++) begin
                                    if (wr_hit_s[k]) begin
                                        wr_regs_r[k*DATA_W +: DATA_W] <= shift_next_s[DATA_W-1:0];
                                    end
                                end
                                wr_strobe_r <= wr_hit_s;
                                ptr_r       <= ptr_inc_s;
                                out_shift_r <= rd_word_s;
                                bit_cnt_r   <= {CNT_W{1'b0}};
                            end else begin
                                bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                        if (sclk_fall_s) begin
                            serial_out_r <= out_shift_r[DATA_W-1];
                            out_shift_r  <= {out_shift_r[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: begin
                        state_r        <= ST_IDLE;
                        bit_cnt_r      <= {CNT_W{1'b0}};
                        frame_active_r <= 1'b0;
                    end
                endcase
                // A quiet sclk ends the frame; any partial word is dropped.
                if (state_r != ST_IDLE) begin
                    if (sclk_edge_s) begin
                        to_cnt_r <= {TO_W{1'b0}};
                    end else if (to_cnt_r == TO_LAST) begin
                        to_cnt_r       <= {TO_W{1'b0}};
                        bit_cnt_r      <= {CNT_W{1'b0}};
                        frame_active_r <= 1'b0;
                        state_r        <= ST_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end

    assign serial_out   = serial_out_r;
    assign frame_active = frame_active_r;
    assign wr_regs      = wr_regs_r;
    assign wr_strobe    = wr_strobe_r;

endmodule
